// File: rtl/pong_pkg.sv
// Shared constants and types for the pong game blocks.
package pong_pkg;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int COORD_W = 10;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 with a right shift.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    VISIBLE = 2'd2
  } pu_state_t;

endpackage

// File: rtl/powerup_lfsr.sv
// Free-running 16-bit Galois LFSR used as the power-up placement source.
module powerup_lfsr
  import pong_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  // An all-zero state would lock the register up, so a zero seed is swapped for 1.
  localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED_SAFE;
    end else begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/powerup_spawner.sv
// Places a power-up on spawn, detects ball pickup once per frame and
// runs the frame-counted effect window.
module powerup_spawner
  import pong_pkg::*;
#(
  parameter int          PU_SIZE       = 16,
  parameter int          BALL_SIZE     = 8,
  parameter int          MARGIN        = 32,
  parameter int          X_SPAN_LOG2   = 9,
  parameter int          Y_SPAN_LOG2   = 8,
  parameter int          EFFECT_FRAMES = 300,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               spawn,
  input  logic               frame_tick,
  input  logic               round_clr,
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  output logic [COORD_W-1:0] pu_x,
  output logic [COORD_W-1:0] pu_y,
  output logic               pu_visible,
  output logic               eaten,
  output logic               effect_active
);

  localparam logic [COORD_W-1:0] MARGIN_C = COORD_W'(MARGIN);
  localparam logic [COORD_W:0]   PU_C     = (COORD_W + 1)'(PU_SIZE);
  localparam logic [COORD_W:0]   BALL_C   = (COORD_W + 1)'(BALL_SIZE);
  localparam logic [8:0]         EFFECT_C = 9'(EFFECT_FRAMES);

  pu_state_t    state;
  logic [15:0]  lfsr;
  logic [8:0]   effect_cnt;
  logic [8:0]   effect_next;
  logic         hit;
  logic         take_hit;
  logic [COORD_W:0] bx, by, px, py;

  powerup_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr)
  );

  // One extra bit keeps the edge sums from wrapping near the right/bottom of the screen.
  always_comb begin
    bx  = {1'b0, ball_x};
    by  = {1'b0, ball_y};
    px  = {1'b0, pu_x};
    py  = {1'b0, pu_y};
    hit = (bx < px + PU_C) && (bx + BALL_C > px) &&
          (by < py + PU_C) && (by + BALL_C > py);
  end

  assign take_hit = (state == VISIBLE) && frame_tick && hit && !round_clr;

  // A pickup reload beats the per-frame decrement; a round clear beats both.
  always_comb begin
    effect_next = effect_cnt;
    if (round_clr) begin
      effect_next = 9'd0;
    end else if (take_hit) begin
      effect_next = EFFECT_C;
    end else if (frame_tick && effect_cnt != 9'd0) begin
      effect_next = effect_cnt - 9'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pu_x          <= '0;
      pu_y          <= '0;
      pu_visible    <= 1'b0;
      eaten         <= 1'b0;
      effect_active <= 1'b0;
      effect_cnt    <= 9'd0;
    end else begin
      eaten         <= 1'b0;
      effect_cnt    <= effect_next;
      effect_active <= (effect_next != 9'd0);
      if (round_clr) begin
        state      <= IDLE;
        pu_visible <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (spawn) begin
              pu_x  <= MARGIN_C + COORD_W'(lfsr[X_SPAN_LOG2-1:0]);
              pu_y  <= MARGIN_C + COORD_W'(lfsr[15 -: Y_SPAN_LOG2]);
              state <= PENDING;
            end
          end
          // Grace frame: the power-up only becomes collidable on the next tick.
          PENDING: begin
            if (frame_tick) begin
              pu_visible <= 1'b1;
              state      <= VISIBLE;
            end
          end
          VISIBLE: begin
            if (take_hit) begin
              eaten      <= 1'b1;
              pu_visible <= 1'b0;
              state      <= IDLE;
            end
          end
          default: begin
            state      <= IDLE;
            pu_visible <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_powerup_spawner.sv
// Directed, table-driven bench for powerup_spawner with an independent LFSR model.
module tb_powerup_spawner;

  localparam int RELEASE_GAP = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spawn;
  logic       frame_tick;
  logic       round_clr;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] pu_x;
  logic [9:0] pu_y;
  logic       pu_visible;
  logic       eaten;
  logic       effect_active;

  logic [15:0] lfsr_m;
  logic [9:0]  exp_x, exp_y, s1_x, s1_y;
  bit          eaten_seen;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int dx;
    int dy;
    bit hit;
  } vec_t;

  vec_t vecs[10];

  powerup_spawner dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .spawn         (spawn),
    .frame_tick    (frame_tick),
    .round_clr     (round_clr),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .pu_x          (pu_x),
    .pu_y          (pu_y),
    .pu_visible    (pu_visible),
    .eaten         (eaten),
    .effect_active (effect_active)
  );

  always #5 clk = ~clk;

  // Taps x^16, x^14, x^13, x^11 land on bits 15, 13, 12 and 10 after the shift.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] n;
    n = v >> 1;
    if (v[0]) n = n ^ (16'h8000 | 16'h2000 | 16'h1000 | 16'h0400);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= 16'hACE1;
    else        lfsr_m <= lfsr_step(lfsr_m);
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drives one cycle of control inputs from a negedge and returns on the next negedge.
  task automatic applyStimulus(input logic s, input logic f, input logic c);
    spawn      = s;
    frame_tick = f;
    round_clr  = c;
    @(negedge clk);
    spawn      = 1'b0;
    frame_tick = 1'b0;
    round_clr  = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) applyStimulus(1'b0, 1'b1, 1'b0);
  endtask

  task automatic ballFar();
    ball_x = 10'd1000;
    ball_y = 10'd1000;
  endtask

  task automatic ballAt(input int dx, input int dy);
    ball_x = 10'(int'(exp_x) + dx);
    ball_y = 10'(int'(exp_y) + dy);
  endtask

  task automatic spawnAndCheck(input string tag, input bit ball_on_spot);
    exp_x = 10'(32 + int'(lfsr_m[8:0]));
    exp_y = 10'(32 + int'(lfsr_m[15:8]));
    if (ball_on_spot) ballAt(4, 4);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput({tag, "_pu_x"}, int'(pu_x), int'(exp_x));
    checkOutput({tag, "_pu_y"}, int'(pu_y), int'(exp_y));
    checkOutput({tag, "_hidden"}, int'(pu_visible), 0);
  endtask

  task automatic makeVisible(input string tag);
    ballFar();
    spawnAndCheck(tag, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput({tag, "_grace_eaten"}, int'(eaten), 0);
    checkOutput({tag, "_shown"}, int'(pu_visible), 1);
  endtask

  task automatic frameCheck(input string tag, input bit exp_hit);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput({tag, "_eaten"}, int'(eaten), int'(exp_hit));
    checkOutput({tag, "_visible"}, int'(pu_visible), int'(!exp_hit));
    if (exp_hit) begin
      checkOutput({tag, "_effect"}, int'(effect_active), 1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput({tag, "_eaten_1cyc"}, int'(eaten), 0);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{dx: 16,  dy: 4,   hit: 1'b0};
    vecs[1] = '{dx: 15,  dy: 4,   hit: 1'b1};
    vecs[2] = '{dx: -8,  dy: 4,   hit: 1'b0};
    vecs[3] = '{dx: -7,  dy: 4,   hit: 1'b1};
    vecs[4] = '{dx: 4,   dy: 16,  hit: 1'b0};
    vecs[5] = '{dx: 4,   dy: 15,  hit: 1'b1};
    vecs[6] = '{dx: 4,   dy: -8,  hit: 1'b0};
    vecs[7] = '{dx: 4,   dy: -7,  hit: 1'b1};
    vecs[8] = '{dx: 200, dy: 200, hit: 1'b0};
    vecs[9] = '{dx: 4,   dy: 4,   hit: 1'b1};

    rst_n      = 1'b1;
    spawn      = 1'b0;
    frame_tick = 1'b0;
    round_clr  = 1'b0;
    ballFar();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_pu_x", int'(pu_x), 0);
    checkOutput("rst_pu_y", int'(pu_y), 0);
    checkOutput("rst_visible", int'(pu_visible), 0);
    checkOutput("rst_eaten", int'(eaten), 0);
    checkOutput("rst_effect", int'(effect_active), 0);
    rst_n = 1'b1;
    repeat (RELEASE_GAP) applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] scenario 1: spawn and grace frame");
    ball_x = 10'd600;
    ball_y = 10'd400;
    spawnAndCheck("s1", 1'b0);
    s1_x = exp_x;
    s1_y = exp_y;
    checkOutput("s1_x_range", int'(pu_x >= 10'd32 && pu_x <= 10'd543), 1);
    checkOutput("s1_y_range", int'(pu_y >= 10'd32 && pu_y <= 10'd287), 1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("s1_hidden_wait", int'(pu_visible), 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("s1_shown", int'(pu_visible), 1);
    eaten_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      eaten_seen |= eaten;
      applyStimulus(1'b0, 1'b0, 1'b0);
      eaten_seen |= eaten;
    end
    checkOutput("s1_no_eaten_10_frames", int'(eaten_seen), 0);
    checkOutput("s1_still_visible", int'(pu_visible), 1);

    $display("[TB] scenario 2: pickup and effect length");
    ballAt(4, 4);
    frameCheck("s2_hit", 1'b1);
    ticks(299);
    checkOutput("s2_effect_after_299", int'(effect_active), 1);
    ticks(1);
    checkOutput("s2_effect_after_300", int'(effect_active), 0);

    $display("[TB] scenario 3: no pickup on grace frame");
    spawnAndCheck("s3", 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("s3_grace_eaten", int'(eaten), 0);
    checkOutput("s3_grace_visible", int'(pu_visible), 1);
    frameCheck("s3_second", 1'b1);

    $display("[TB] scenario 4: overlap edges");
    for (int i = 0; i < 10; i++) begin
      makeVisible($sformatf("s4_v%0d_setup", i));
      ballAt(vecs[i].dx, vecs[i].dy);
      frameCheck($sformatf("s4_v%0d", i), vecs[i].hit);
      if (!vecs[i].hit) begin
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput($sformatf("s4_v%0d_clr_visible", i), int'(pu_visible), 0);
      end
    end

    $display("[TB] scenario 5: priorities");
    makeVisible("s5a");
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("s5a_spawn_ignored_x", int'(pu_x), int'(exp_x));
    checkOutput("s5a_spawn_ignored_y", int'(pu_y), int'(exp_y));
    frameCheck("s5a_still_visible", 1'b0);
    checkOutput("s5b_effect_before", int'(effect_active), 1);
    ballAt(4, 4);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("s5b_clr_eaten", int'(eaten), 0);
    checkOutput("s5b_clr_visible", int'(pu_visible), 0);
    checkOutput("s5b_clr_effect", int'(effect_active), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("s5b_clr_eaten_late", int'(eaten), 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("s5b_idle_no_hit", int'(eaten), 0);
    ballFar();
    spawnAndCheck("s5b_idle_spawn", 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("s5c_shown", int'(pu_visible), 1);
    ballAt(4, 4);
    frameCheck("s5c_first", 1'b1);
    ticks(294);
    makeVisible("s5c_respawn");
    checkOutput("s5c_effect_at_5", int'(effect_active), 1);
    ballAt(4, 4);
    frameCheck("s5c_second", 1'b1);
    ticks(299);
    checkOutput("s5c_reload_299", int'(effect_active), 1);
    ticks(1);
    checkOutput("s5c_reload_300", int'(effect_active), 0);

    $display("[TB] scenario 6: reset mid-effect");
    makeVisible("s6_pre");
    ballAt(4, 4);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("s6_pre_eaten", int'(eaten), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("s6_async_pu_x", int'(pu_x), 0);
    checkOutput("s6_async_pu_y", int'(pu_y), 0);
    checkOutput("s6_async_visible", int'(pu_visible), 0);
    checkOutput("s6_async_eaten", int'(eaten), 0);
    checkOutput("s6_async_effect", int'(effect_active), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (RELEASE_GAP) applyStimulus(1'b0, 1'b0, 1'b0);
    ballFar();
    spawnAndCheck("s6", 1'b0);
    checkOutput("s6_repeat_x", int'(pu_x), int'(s1_x));
    checkOutput("s6_repeat_y", int'(pu_y), int'(s1_y));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
